cluster_clock_switch_ctrl: RTL

CLUSTER_CLOCK_SWITCH_CTRL -- requirements
Module: cluster_clock_switch_ctrl

---
 rtl/cluster_clock_pkg.sv | 19 +
 rtl/cluster_clock_sync.sv | 24 ++
 rtl/cluster_clock_switch_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/cluster_clock_pkg.sv
// Shared types and defaults for the cluster clock-source switch controller.
package cluster_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GATE_OFF = 2'd1,
        ST_SETTLE   = 2'd2
    } ccs_state_e;

    localparam int unsigned GATE_CYCLES_DEF   = 32'd4;
    localparam int unsigned SETTLE_CYCLES_DEF = 32'd4;
    localparam int unsigned CNT_W             = 32'd8;

    // Counters run down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] load_cnt(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/cluster_clock_sync.sv
// Two-flop synchronizer for a single asynchronous control bit.
module cluster_clock_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Capture stage followed by the resolved output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/cluster_clock_switch_ctrl.sv
// Glitch-free clock source switch sequencer: gate the clock, flip the mux
// select, let it settle, then re-enable the clock.
module cluster_clock_switch_ctrl
    import cluster_clock_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic        RST_SEL       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sel_i,
    output logic clk_sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] GATE_LOAD   = load_cnt(GATE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = load_cnt(SETTLE_CYCLES);

    logic             sel_s;
    ccs_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             target_r;

    cluster_clock_sync #(
        .RST_VAL (RST_SEL)
    ) u_sel_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (sel_i),
        .q     (sel_s)
    );

    // Switch sequencer; every output is a flop written only here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            target_r  <= RST_SEL;
            clk_sel_o <= RST_SEL;
            clk_en_o  <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_s != clk_sel_o) begin
                        state_r  <= ST_GATE_OFF;
                        clk_en_o <= 1'b0;
                        busy_o   <= 1'b1;
                        target_r <= sel_s;
                        cnt_r    <= GATE_LOAD;
                    end
                end
                ST_GATE_OFF: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r   <= ST_SETTLE;
                        clk_sel_o <= target_r;
                        cnt_r     <= SETTLE_LOAD;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r  <= ST_IDLE;
                        clk_en_o <= 1'b1;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a safe, clock-enabled idle.
                    state_r  <= ST_IDLE;
                    cnt_r    <= {CNT_W{1'b0}};
                    clk_en_o <= 1'b1;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
